// File: rtl/vga_timing_gen.sv
// vga_timing_gen - VGA scan timing source for the graphics controller.
//
// Produces the pixel strobe and scan coordinates used by the sprite/tank
// overlay stages, plus active-low hsync/vsync and blank.  Sync and blank are
// delayed by PIPE_DELAY pixel ticks so they line up with RGB returning from
// sprite memory.  vblank_o and frame_start_o let the CPU side rewrite sprite
// positions only outside the visible area.
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            asynchronous active-high reset
//   en_i           run enable; low freezes divider, counters and delay line
//   pix_tick_o     one-clk strobe per pixel (high in the clk the coordinates
//                  change)
//   x_pos_o        horizontal count, zero-extended to 32 bits
//   y_pos_o        vertical count, zero-extended to 32 bits
//   hsync_o        active-low hsync, delayed PIPE_DELAY ticks
//   vsync_o        active-low vsync, delayed PIPE_DELAY ticks
//   blank_o        high outside the visible area, delayed PIPE_DELAY ticks
//   vblank_o       high while y_pos_o >= V_VISIBLE (undelayed)
//   frame_start_o  one-clk pulse when the counters wrap to (0,0)
//   frame_count_o  frames completed
//
// Optional build macro: VGA_FRAME_COUNT_EN enables the 32-bit frame counter
// on frame_count_o; without it frame_count_o is tied to zero.
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic        pix_tick_o,
    output logic [31:0] x_pos_o,
    output logic [31:0] y_pos_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_o,
    output logic        vblank_o,
    output logic        frame_start_o,
    output logic [31:0] frame_count_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    localparam logic [31:0] H_VIS_L  = 32'(H_VISIBLE);
    localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [31:0] V_VIS_L  = 32'(V_VISIBLE);
    localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          pix_tick_q, pix_tick_d;
    logic          frame_start_q, frame_start_d;
    logic          advance;
    logic [31:0]   h_ext, v_ext;
    logic          hs_raw, vs_raw, bl_raw;

    // The counters move on the same edge that raises pix_tick, so the strobe
    // marks the first clk of each new pixel.
    always_comb begin
        advance       = en_i && (div_q == DIV_LAST);
        div_d         = div_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pix_tick_d    = advance;
        frame_start_d = advance && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

        // Divider only moves while enabled, so a pending tick survives a pause.
        if (en_i) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end

        if (advance) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Decode from the registered counters.
    always_comb begin
        h_ext  = 32'(h_cnt_q);
        v_ext  = 32'(v_cnt_q);
        hs_raw = !((h_ext >= HS_START) && (h_ext < HS_END));
        vs_raw = !((v_ext >= VS_START) && (v_ext < VS_END));
        bl_raw = (h_ext >= H_VIS_L) || (v_ext >= V_VIS_L);
    end

    assign pix_tick_o    = pix_tick_q;
    assign frame_start_o = frame_start_q;
    assign x_pos_o       = h_ext;
    assign y_pos_o       = v_ext;
    assign vblank_o      = (v_ext >= V_VIS_L);

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign hsync_o = hs_raw;
            assign vsync_o = vs_raw;
            assign blank_o = bl_raw;
        end else begin : g_pipe
            // Each stage holds {hsync, vsync, blank}; the line shifts once per
            // pixel tick so the delay is measured in pixels, not clks.
            logic [2:0] stage_q [PIPE_DELAY];
            logic [2:0] stage_d [PIPE_DELAY];

            always_comb begin
                stage_d = stage_q;
                if (advance) begin
                    stage_d[0] = {hs_raw, vs_raw, bl_raw};
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            // Stages preload to the idle (sync inactive, blanked) pattern so
            // no partial pulse leaves the line after reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage_q[i] <= 3'b111;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign {hsync_o, vsync_o, blank_o} = stage_q[PIPE_DELAY-1];
        end
    endgenerate

`ifdef VGA_FRAME_COUNT_EN
    logic [31:0] frame_count_q, frame_count_d;

    // Counts on the same edge that raises frame_start_o; wraps naturally.
    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count_o = frame_count_q;
`else
    assign frame_count_o = '0;
`endif

endmodule
